sr_pq: RTL and testbench
========================

Name: sr_pq

Overview:
- Shift-register hardware priority queue: a linear array of DEPTH registered cells kept sorted, with the highest-priority entry always at cell 0.
- Serves as the storage stage behind the shared HWPQ interface.
- Consumes pq_pkg types and ordering: kv_t, KV_EMPTY, cmp_kv_gt and PQ_TYPE.
- Accepts one enqueue, one dequeue, or one simultaneous replace per clock; the head is always visible on kvo.

Parameters:
- DEPTH, 16: number of cells, i.e. queue capacity (>= 2).
- CW, $clog2(DEPTH+1): width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enq  input  1  enqueue request; kvi is sampled at this clock edge.
- kvi  input  $bits(kv_t)  key/value pair to insert.
- deq  input  1  dequeue request; removes the head at this clock edge.
- kvo  output  $bits(kv_t)  current head (cell 0); KV_EMPTY when the queue is empty.
- count  output  CW  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow flag: enq while full without deq.
- udf  output  1  sticky underflow flag: deq while empty.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). All state clears immediately on rst_n low, independent of clk.
- Reset values: every cell = KV_EMPTY with valid=0, kvo=KV_EMPTY, count=0, empty=1, full=0, ovf=0, udf=0.
- Reset mid-operation discards all contents. The first edge after rst_n rises behaves as on an empty queue.
- State per cell i: data[i] (kv_t) and valid[i]. Valid cells are contiguous from index 0 and sorted.
- All outputs are registered or are direct decodes of registers. No combinational path from enq, deq or kvi to any output.
- Latency: an operation sampled at edge N is reflected on kvo, count, full and empty after edge N (one cycle).
- Insert position p for kvi is the lowest i such that valid[i]=0 or cmp_kv_gt(kvi, data[i]) = 1.
  - Ties go behind existing equal keys, so equal keys leave in FIFO order.
- Operation decode at each edge, as (enq, deq, state):
  - 0,0: hold.
  - 1,0, not full: cells i>p take cell i-1; cell p takes kvi (valid=1); cells i<p hold; count+1.
  - 1,0, full: no change to cells or count; ovf<=1.
  - 0,1, not empty: every cell i takes cell i+1; cell DEPTH-1 becomes KV_EMPTY/invalid; count-1.
  - 0,1, empty: no change; udf<=1.
  - 1,1, not empty (full allowed): replace, count unchanged.
    - Compute p over cells 1..DEPTH-1 of the pre-shift array.
    - After the shift, kvi lands at index max(p-1, 0); cells between shift left accordingly.
    - Net effect equals a dequeue followed by an enqueue in the same edge.
  - 1,1, empty: treated as enq only; count=1; udf is not set.
- Comparisons use only cmp_kv_gt, so PQ_TYPE selects MIN or MAX ordering with no RTL change.
- Validity comes from valid bits, never from key sentinels. Keys equal to KEYINF or KEYNEGINF must still be stored and ordered correctly.
- ovf and udf clear only on reset.
- count never exceeds DEPTH and never wraps below 0.

Test Plan:
- Ordering (MIN_PQ, DEPTH=16): enq (5,1), (3,2), (9,3) on consecutive cycles.
  - Required: kvo=(3,2) and count=3 one cycle after the last enq.
  - Then three deqs: kvo goes (5,1), (9,3), KV_EMPTY; empty=1.
- Ties: enq (4,10) then (4,11) then (2,7).
  - Required dequeue order: (2,7), (4,10), (4,11).
- Full/overflow (DEPTH=4): enq keys 8,6,4,2, then enq (1,0).
  - Required: full=1, ovf=1, count=4, kvo=(2,*), and key 1 is never seen.
  - Then enq (1,0) with deq in the same cycle: kvo=(1,0), count=4.
- Replace: queue holds keys 3,7 (values 0). enq (5,9) and deq in the same cycle.
  - Required: count=2, kvo=(5,9); the next deq yields (7,0).
- Underflow and empty corner: deq on empty → udf=1, count=0.
  - Then enq+deq together on empty → kvo=kvi, count=1.
  - enq key=8'hFF (KEYINF) → stored; count increments.
- Async reset: with 3 entries, assert rst_n low between clock edges.
  - Required: outputs reach reset values before the next edge.
  - After release, enq (6,6) gives kvo=(6,6), count=1.

Source files
------------

// File: rtl/sr_pq.sv
// Shift-register priority queue: DEPTH sorted registered cells with the head at cell 0.
// Ordering comes only from pq_pkg::cmp_kv_gt, so MIN/MAX is chosen in the package.

package pq_pkg;
    localparam int KW = 8;
    localparam int VW = 8;

    typedef enum logic {MIN_PQ = 1'b0, MAX_PQ = 1'b1} pq_type_e;
    localparam pq_type_e PQ_TYPE = MIN_PQ;

    localparam logic [KW-1:0] KEYINF    = 8'hFF;
    localparam logic [KW-1:0] KEYNEGINF = 8'h00;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } kv_t;

    localparam kv_t KV_EMPTY = (PQ_TYPE == MIN_PQ) ? {KEYINF, {VW{1'b0}}} : {KEYNEGINF, {VW{1'b0}}};

    // True when a has strictly higher priority than b.
    function automatic logic cmp_kv_gt(input kv_t a, input kv_t b);
        if (PQ_TYPE == MIN_PQ) begin
            return (a.key < b.key);
        end else begin
            return (a.key > b.key);
        end
    endfunction
endpackage

module sr_pq
    import pq_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq,
    input  kv_t           kvi,
    input  logic          deq,
    output kv_t           kvo,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          udf
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_ENQ  = 3'd1,
        OP_DEQ  = 3'd2,
        OP_REPL = 3'd3,
        OP_OVF  = 3'd4,
        OP_UDF  = 3'd5
    } op_e;

    kv_t             r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_udf;

    kv_t             w_data_nxt [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [CW-1:0]   w_count_nxt;
    logic            w_ovf_nxt;
    logic            w_udf_nxt;

    kv_t             w_data_ext [DEPTH+1];
    logic [DEPTH:0]  w_valid_ext;
    logic [DEPTH:0]  w_gt;
    logic [DEPTH:0]  w_gt_prev;
    logic            w_empty;
    logic            w_full;
    op_e             w_op;

    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));

    // Per-cell "kvi goes before this cell"; an extra always-true slot sits past the end.
    always_comb begin
        w_gt        = '0;
        w_valid_ext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_data_ext[i]  = r_data[i];
            w_valid_ext[i] = r_valid[i];
            w_gt[i]        = !r_valid[i] || cmp_kv_gt(kvi, r_data[i]);
        end
        w_data_ext[DEPTH]  = KV_EMPTY;
        w_valid_ext[DEPTH] = 1'b0;
        w_gt[DEPTH]        = 1'b1;
    end

    assign w_gt_prev = {w_gt[DEPTH-1:0], 1'b0};

    // Decode the requested operation against the current occupancy.
    always_comb begin
        w_op = OP_HOLD;
        case ({enq, deq})
            2'b10:   w_op = w_full  ? OP_OVF : OP_ENQ;
            2'b01:   w_op = w_empty ? OP_UDF : OP_DEQ;
            2'b11:   w_op = w_empty ? OP_ENQ : OP_REPL;
            default: w_op = OP_HOLD;
        endcase
    end

    // Next cell contents; sorted order is kept because w_gt is monotonic along the array.
    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        case (w_op)
            OP_ENQ: begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (w_gt_prev[k]) begin
                        w_data_nxt[k]  = w_data_ext[k-1];
                        w_valid_nxt[k] = w_valid_ext[k-1];
                    end else if (w_gt[k]) begin
                        w_data_nxt[k]  = kvi;
                        w_valid_nxt[k] = 1'b1;
                    end else begin
                        w_data_nxt[k]  = r_data[k];
                        w_valid_nxt[k] = r_valid[k];
                    end
                end
                w_count_nxt = r_count + CW'(1);
            end
            OP_DEQ: begin
                for (int k = 0; k < DEPTH; k++) begin
                    w_data_nxt[k]  = w_data_ext[k+1];
                    w_valid_nxt[k] = w_valid_ext[k+1];
                end
                w_count_nxt = r_count - CW'(1);
            end
            OP_REPL: begin
                // Cell 0 leaves; the insert point ignores cell 0 and lands one slot earlier.
                for (int k = 0; k < DEPTH; k++) begin
                    if (!w_gt[k+1]) begin
                        w_data_nxt[k]  = w_data_ext[k+1];
                        w_valid_nxt[k] = w_valid_ext[k+1];
                    end else if ((k == 0) || !w_gt[k]) begin
                        w_data_nxt[k]  = kvi;
                        w_valid_nxt[k] = 1'b1;
                    end else begin
                        w_data_nxt[k]  = r_data[k];
                        w_valid_nxt[k] = r_valid[k];
                    end
                end
            end
            OP_OVF:  w_ovf_nxt = 1'b1;
            OP_UDF:  w_udf_nxt = 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= KV_EMPTY;
            end
            r_valid <= '0;
            r_count <= CW'(0);
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign kvo   = r_data[0];
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: tb/tb_sr_pq.sv
// Scoreboard bench for sr_pq: DEPTH=16 and DEPTH=4 instances share stimulus,
// each checked against a sorted-queue reference model.
module tb_sr_pq;
    import pq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic enq   = 1'b0;
    logic deq   = 1'b0;
    kv_t  kvi   = '0;

    kv_t        kvo_a, kvo_b;
    logic [4:0] count_a;
    logic [2:0] count_b;
    logic       empty_a, full_a, ovf_a, udf_a;
    logic       empty_b, full_b, ovf_b, udf_b;

    sr_pq #(.DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enq(enq), .kvi(kvi), .deq(deq),
        .kvo(kvo_a), .count(count_a), .empty(empty_a), .full(full_a),
        .ovf(ovf_a), .udf(udf_a)
    );

    sr_pq #(.DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enq(enq), .kvi(kvi), .deq(deq),
        .kvo(kvo_b), .count(count_b), .empty(empty_b), .full(full_b),
        .ovf(ovf_b), .udf(udf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        kv_t kvo;
        int  count;
        bit  empty;
        bit  full;
        bit  ovf;
        bit  udf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    kv_t  ma[$];
    kv_t  mb[$];
    bit   ovfa, udfa, ovfb, udfb;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a sorted list, lower key first, equal keys in arrival order.
    task automatic model_step(input int depth, inout kv_t m[$], inout bit ov, inout bit ud,
                              input bit e, input bit d, input kv_t k);
        bit do_ins;
        int pos;
        do_ins = 1'b0;
        if (e && d && m.size() > 0) begin
            void'(m.pop_front());
            do_ins = 1'b1;
        end else if (e) begin
            if (m.size() < depth) do_ins = 1'b1;
            else ov = 1'b1;
        end else if (d) begin
            if (m.size() > 0) void'(m.pop_front());
            else ud = 1'b1;
        end
        if (do_ins) begin
            pos = m.size();
            for (int i = 0; i < m.size(); i++) begin
                if (k.key < m[i].key) begin
                    pos = i;
                    break;
                end
            end
            m.insert(pos, k);
        end
    endtask

    function automatic exp_t mk_exp(input kv_t m[$], input int depth, input bit ov, input bit ud);
        exp_t e;
        e.kvo   = (m.size() > 0) ? m[0] : KV_EMPTY;
        e.count = m.size();
        e.empty = (m.size() == 0);
        e.full  = (m.size() == depth);
        e.ovf   = ov;
        e.udf   = ud;
        return e;
    endfunction

    task automatic cmp_dut(input string tag, input exp_t e, input kv_t kvo, input int cnt,
                           input bit emp, input bit ful, input bit ov, input bit ud);
        chk({tag, "_kvo"},   32'(kvo), 32'(e.kvo));
        chk({tag, "_count"}, 32'(cnt), 32'(e.count));
        chk({tag, "_empty"}, 32'(emp), 32'(e.empty));
        chk({tag, "_full"},  32'(ful), 32'(e.full));
        chk({tag, "_ovf"},   32'(ov),  32'(e.ovf));
        chk({tag, "_udf"},   32'(ud),  32'(e.udf));
    endtask

    // Issue one operation at the falling edge and queue what each DUT must show after the next rise.
    task automatic op(input bit e, input bit d, input kv_t k);
        @(negedge clk);
        enq = e;
        deq = d;
        kvi = k;
        model_step(16, ma, ovfa, udfa, e, d, k);
        model_step(4,  mb, ovfb, udfb, e, d, k);
        qa.push_back(mk_exp(ma, 16, ovfa, udfa));
        qb.push_back(mk_exp(mb, 4,  ovfb, udfb));
    endtask

    function automatic kv_t mkkv(input int k, input int v);
        kv_t x;
        x.key   = k[7:0];
        x.value = v[7:0];
        return x;
    endfunction

    // Drop rst_n between edges and check that outputs clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        ma.delete();
        mb.delete();
        ovfa = 1'b0; udfa = 1'b0; ovfb = 1'b0; udfb = 1'b0;
        cmp_dut("rst16", mk_exp(ma, 16, 1'b0, 1'b0), kvo_a, int'(count_a), empty_a, full_a, ovf_a, udf_a);
        cmp_dut("rst4",  mk_exp(mb, 4,  1'b0, 1'b0), kvo_b, int'(count_b), empty_b, full_b, ovf_b, udf_b);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per DUT after each rising edge.
    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && qa.size() > 0) begin
                ea = qa.pop_front();
                cmp_dut("d16", ea, kvo_a, int'(count_a), empty_a, full_a, ovf_a, udf_a);
            end
            if (rst_n && qb.size() > 0) begin
                eb = qb.pop_front();
                cmp_dut("d4", eb, kvo_b, int'(count_b), empty_b, full_b, ovf_b, udf_b);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        kv_t k;
        int  r;

        do_reset();
        op(1'b1, 1'b0, mkkv(5, 1));
        op(1'b1, 1'b0, mkkv(3, 2));
        op(1'b1, 1'b0, mkkv(9, 3));
        repeat (3) op(1'b0, 1'b1, mkkv(0, 0));
        op(1'b0, 1'b0, mkkv(0, 0));

        do_reset();
        op(1'b1, 1'b0, mkkv(4, 10));
        op(1'b1, 1'b0, mkkv(4, 11));
        op(1'b1, 1'b0, mkkv(2, 7));
        repeat (3) op(1'b0, 1'b1, mkkv(0, 0));

        do_reset();
        op(1'b1, 1'b0, mkkv(8, 0));
        op(1'b1, 1'b0, mkkv(6, 0));
        op(1'b1, 1'b0, mkkv(4, 0));
        op(1'b1, 1'b0, mkkv(2, 0));
        op(1'b1, 1'b0, mkkv(1, 0));
        op(1'b1, 1'b1, mkkv(1, 0));
        repeat (5) op(1'b0, 1'b1, mkkv(0, 0));

        do_reset();
        op(1'b1, 1'b0, mkkv(3, 0));
        op(1'b1, 1'b0, mkkv(7, 0));
        op(1'b1, 1'b1, mkkv(5, 9));
        op(1'b0, 1'b1, mkkv(0, 0));
        op(1'b0, 1'b1, mkkv(0, 0));

        do_reset();
        op(1'b0, 1'b1, mkkv(0, 0));
        op(1'b1, 1'b1, mkkv(8'h20, 5));
        op(1'b1, 1'b0, mkkv(8'hFF, 3));
        op(1'b1, 1'b0, mkkv(8'h00, 4));
        op(1'b1, 1'b0, mkkv(8'hFF, 1));
        repeat (5) op(1'b0, 1'b1, mkkv(0, 0));

        do_reset();
        op(1'b1, 1'b0, mkkv(12, 1));
        op(1'b1, 1'b0, mkkv(11, 2));
        op(1'b1, 1'b0, mkkv(13, 3));
        op(1'b0, 1'b0, mkkv(0, 0));
        do_reset();
        op(1'b1, 1'b0, mkkv(6, 6));
        op(1'b0, 1'b0, mkkv(0, 0));

        do_reset();
        for (int i = 0; i < 18; i++) op(1'b1, 1'b0, mkkv($urandom_range(0, 7), i));
        op(1'b1, 1'b1, mkkv(3, 99));
        op(1'b1, 1'b1, mkkv(8'hFF, 98));
        for (int i = 0; i < 18; i++) op(1'b0, 1'b1, mkkv(0, 0));

        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) k.key = ($urandom_range(0, 1) == 0) ? KEYINF : KEYNEGINF;
            else k.key = 8'($urandom_range(0, 15));
            k.value = 8'($urandom_range(0, 255));
            if (r <= 3)      op(1'b1, 1'b0, k);
            else if (r <= 6) op(1'b0, 1'b1, k);
            else if (r <= 8) op(1'b1, 1'b1, k);
            else             op(1'b0, 1'b0, k);
        end
        op(1'b0, 1'b0, mkkv(0, 0));

        for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", 32'(qa.size() + qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
